// File: rtl/wash_billing_pkg.sv
// Shared definitions for the coin-op washer billing block: state codes,
// BCD limits, size encoding and a BCD helper used for elaboration-time constants.
package wash_billing_pkg;

  typedef logic [11:0] bcd_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WASH = 3'd1;
  localparam logic [2:0] ST_DRY  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_PAY  = 3'd4;

  localparam bcd_t BCD_MAX  = 12'h999;
  localparam bcd_t BCD_ZERO = 12'h000;
  localparam bcd_t BCD_ONE  = 12'h001;

  localparam logic [1:0] SIZE_NONE  = 2'd0;
  localparam logic [1:0] SIZE_SMALL = 2'd1;
  localparam logic [1:0] SIZE_MED   = 2'd2;
  localparam logic [1:0] SIZE_BIG   = 2'd3;

  function automatic int bcd_to_int(input bcd_t v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

endpackage

// File: rtl/wash_billing_bcd_add3.sv
// Three-digit BCD adder/subtractor; clamps to 999 on carry-out and to 000 on
// borrow-out so no amount or timer ever wraps.
module bcd_add3
  import wash_billing_pkg::*;
(
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic        sub,
  output logic [11:0] y
);

  function automatic bcd_t bcd_addsub_sat(input bcd_t x, input bcd_t z, input logic do_sub);
    bcd_t       r;
    logic       c;
    logic [4:0] d;
    r = BCD_ZERO;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (do_sub) begin
        // bit 4 of the 5-bit difference is the digit borrow
        d = {1'b0, x[4*i +: 4]} - {1'b0, z[4*i +: 4]} - {4'b0, c};
        c = d[4];
        if (c) d = d + 5'd10;
      end else begin
        d = {1'b0, x[4*i +: 4]} + {1'b0, z[4*i +: 4]} + {4'b0, c};
        c = (d > 5'd9);
        if (c) d = d - 5'd10;
      end
      r[4*i +: 4] = d[3:0];
    end
    if (c) r = do_sub ? BCD_ZERO : BCD_MAX;
    return r;
  endfunction

  assign y = bcd_addsub_sat(a, b, sub);

endmodule

// File: rtl/wash_billing.sv
// Washer order controller: runs wash/dry timers on a one-second tick, accrues
// overtime fines while laundry waits, and accumulates takings and run time.
module wash_billing
  import wash_billing_pkg::*;
#(
  parameter int          TICK_DIV    = 100000000,
  parameter logic [11:0] WASH_S      = 12'h030,
  parameter logic [11:0] WASH_M      = 12'h045,
  parameter logic [11:0] WASH_B      = 12'h060,
  parameter logic [11:0] DRY_T       = 12'h020,
  parameter logic [11:0] FINE_PERIOD = 12'h010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        start,
  input  logic        collect,
  input  logic [1:0]  size,
  input  logic        dry,
  input  logic [11:0] dy_price,
  input  logic [11:0] s_price,
  input  logic [11:0] m_price,
  input  logic [11:0] b_price,
  input  logic [11:0] setfine,
  output logic [2:0]  st,
  output logic [11:0] remain,
  output logic [11:0] charge,
  output logic [11:0] profit,
  output logic [11:0] runtime,
  output logic        done
);

  localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam int               FINE_N    = bcd_to_int(FINE_PERIOD);
  localparam logic [9:0]       FINE_LAST = 10'(FINE_N - 1);

  logic [CNT_W-1:0] cnt;
  logic [9:0]       fcnt;
  logic             dry_l;
  bcd_t             fine_l;
  logic             timed, tick, go, fine_hit;
  bcd_t             price_sel, wash_sel, add_a, add_b;
  bcd_t             charge_sum, profit_sum, runtime_sum, remain_step;

  assign timed    = on && ((st == ST_WASH) || (st == ST_DRY) || (st == ST_WAIT));
  assign tick     = timed && (cnt == CNT_LAST);
  assign go       = on && start && (st == ST_IDLE) && (size != SIZE_NONE);
  assign fine_hit = (FINE_N != 0) && (fcnt == FINE_LAST);
  assign done     = (st == ST_WAIT);

  always_comb begin
    price_sel = BCD_ZERO;
    wash_sel  = BCD_ZERO;
    case (size)
      SIZE_SMALL: begin price_sel = s_price; wash_sel = WASH_S; end
      SIZE_MED:   begin price_sel = m_price; wash_sel = WASH_M; end
      SIZE_BIG:   begin price_sel = b_price; wash_sel = WASH_B; end
      default:    begin price_sel = BCD_ZERO; wash_sel = BCD_ZERO; end
    endcase
  end

  // One adder serves both the order price at start and fine accrual in WAIT.
  assign add_a = (st == ST_IDLE) ? price_sel : charge;
  assign add_b = (st == ST_IDLE) ? (dry ? dy_price : BCD_ZERO) : fine_l;

  bcd_add3 u_charge  (.a(add_a),   .b(add_b),   .sub(1'b0),           .y(charge_sum));
  bcd_add3 u_profit  (.a(profit),  .b(charge),  .sub(1'b0),           .y(profit_sum));
  bcd_add3 u_runtime (.a(runtime), .b(BCD_ONE), .sub(1'b0),           .y(runtime_sum));
  bcd_add3 u_remain  (.a(remain),  .b(BCD_ONE), .sub(st != ST_WAIT),  .y(remain_step));

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_IDLE;
      remain  <= BCD_ZERO;
      charge  <= BCD_ZERO;
      profit  <= BCD_ZERO;
      runtime <= BCD_ZERO;
      cnt     <= '0;
      fcnt    <= '0;
      dry_l   <= 1'b0;
      fine_l  <= BCD_ZERO;
    end else if (on) begin
      if (timed) cnt <= tick ? '0 : cnt + 1'b1;
      case (st)
        ST_IDLE: begin
          if (go) begin
            st     <= ST_WASH;
            dry_l  <= dry;
            fine_l <= setfine;
            charge <= charge_sum;
            remain <= wash_sel;
            cnt    <= '0;
          end
        end
        ST_WASH: begin
          fcnt <= '0;
          if (tick) begin
            runtime <= runtime_sum;
            remain  <= remain_step;
            if (remain_step == BCD_ZERO) begin
              if (dry_l) begin
                st     <= ST_DRY;
                remain <= DRY_T;
              end else begin
                st <= ST_WAIT;
              end
            end
          end
        end
        ST_DRY: begin
          fcnt <= '0;
          if (tick) begin
            runtime <= runtime_sum;
            remain  <= remain_step;
            if (remain_step == BCD_ZERO) st <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // collect takes priority over a fine landing on the same tick
          if (collect) begin
            st <= ST_PAY;
          end else if (tick) begin
            remain <= remain_step;
            if (fine_hit) begin
              charge <= charge_sum;
              fcnt   <= '0;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        ST_PAY: begin
          profit <= profit_sum;
          charge <= BCD_ZERO;
          remain <= BCD_ZERO;
          st     <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
